// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling unit.
package pool_pkg;

  typedef enum logic [1:0] {
    POOL_MAX  = 2'b00,
    POOL_MEAN = 2'b01,
    POOL_MIN  = 2'b10,
    POOL_SUM  = 2'b11
  } pool_mode_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'b00,
    P_ACC  = 2'b01,
    P_OUT  = 2'b10
  } pool_state_e;

  // Clamp v to the signed range of a w-bit value (w < 64).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/pooling_stream_if.sv
// Valid/ready stream carrying one packed vector of per-channel samples.
interface pooling_stream_if #(
  parameter int unsigned DW = 8
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pool_lane.sv
// One pooling channel: holds the window accumulator and produces the finalized result.
module pool_lane
  import pool_pkg::*;
#(
  parameter int unsigned W  = 20,
  parameter int unsigned CW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         seed_i,
  input  logic         update_i,
  input  pool_mode_e   mode_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] res_o
);

  localparam int unsigned AW = W + CW;

  logic signed [AW-1:0] sample;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [63:0]   sum_sat;
  logic                 unused_sat;

  assign sample = {{CW{data_i[W-1]}}, data_i};

  always_comb begin
    acc_d = acc_q;
    if (seed_i) begin
      acc_d = sample;
    end else if (update_i) begin
      case (mode_i)
        POOL_MAX: if (sample > acc_q) acc_d = sample;
        POOL_MIN: if (sample < acc_q) acc_d = sample;
        default:  acc_d = acc_q + sample;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Result reflects acc_d so the element accepted on the final edge is included.
  assign sum_sat    = saturate(64'(acc_d), W);
  assign unused_sat = ^sum_sat[63:W];

  always_comb begin
    res_o = acc_d[W-1:0];
    case (mode_i)
      POOL_MEAN: res_o = W'(acc_d >>> CW);
      POOL_SUM:  res_o = sum_sat[W-1:0];
      default:   res_o = acc_d[W-1:0];
    endcase
  end

endmodule

// File: rtl/pooling_stream.sv
// Multi-channel streaming pooler: reduces WIN elements per channel to one result per window.
module pooling_stream
  import pool_pkg::*;
#(
  parameter int unsigned IL  = 8,
  parameter int unsigned FL  = 12,
  parameter int unsigned CH  = 4,
  parameter int unsigned WIN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  clear,
  pooling_stream_if.slave       in_if,
  pooling_stream_if.master      out_if,
  output logic [1:0]            out_mode,
  output logic [1:0]            state
);

  localparam int unsigned W  = IL + FL;
  localparam int unsigned CW = $clog2(WIN);

  pool_state_e     state_q;
  pool_mode_e      mode_q;
  pool_mode_e      out_mode_q;
  logic            out_valid_q;
  logic [CH*W-1:0] out_data_q;
  logic [CW-1:0]   cnt_q;
  logic [CH*W-1:0] res;
  logic            in_ready;
  logic            accept;
  logic            seed;
  logic            update;

  assign in_ready = (state_q != P_OUT);
  assign accept   = in_if.valid & in_ready;
  // Clear wins over a same-cycle element, so lanes must not see it either.
  assign seed     = accept & ~clear & (state_q == P_IDLE);
  assign update   = accept & ~clear & (state_q == P_ACC);

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pool_lane #(
      .W (W),
      .CW(CW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear),
      .seed_i  (seed),
      .update_i(update),
      .mode_i  (mode_q),
      .data_i  (in_if.data[c*W +: W]),
      .res_o   (res[c*W +: W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= P_IDLE;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      if (reset) begin
        mode_q     <= POOL_MAX;
        out_mode_q <= POOL_MAX;
        out_data_q <= '0;
      end
    end else begin
      unique case (state_q)
        P_IDLE: begin
          if (accept) begin
            mode_q  <= pool_mode_e'(mode);
            cnt_q   <= CW'(1);
            state_q <= P_ACC;
          end
        end
        P_ACC: begin
          if (accept) begin
            if (cnt_q == CW'(WIN - 1)) begin
              out_data_q  <= res;
              out_mode_q  <= mode_q;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= P_OUT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        P_OUT: begin
          if (out_if.ready) begin
            out_valid_q <= 1'b0;
            state_q     <= P_IDLE;
          end
        end
        default: state_q <= P_IDLE;
      endcase
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign out_mode     = out_mode_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pooling_stream.sv
// Directed bench for pooling_stream with CH=2, WIN=4, IL=8, FL=12.
module tb_pooling_stream;

  localparam int unsigned IL  = 8;
  localparam int unsigned FL  = 12;
  localparam int unsigned CH  = 2;
  localparam int unsigned WIN = 4;
  localparam int unsigned W   = IL + FL;

  typedef struct packed {
    logic [1:0]          mode;
    logic [3:0][W-1:0]   a0;
    logic [3:0][W-1:0]   a1;
    logic [W-1:0]        e0;
    logic [W-1:0]        e1;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic       clear;
  logic [1:0] out_mode;
  logic [1:0] state;
  int         checks;
  int         errors;
  vec_t       vecs[6];

  pooling_stream_if #(.DW(CH * W)) in_if ();
  pooling_stream_if #(.DW(CH * W)) out_if ();

  pooling_stream #(
    .IL (IL),
    .FL (FL),
    .CH (CH),
    .WIN(WIN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .clear   (clear),
    .in_if   (in_if),
    .out_if  (out_if),
    .out_mode(out_mode),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic longint sx(input logic [W-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input int x0, input int x1, input int x2,
                              input int x3, input int y0, input int y1, input int y2,
                              input int y3, input int e0, input int e1);
    vec_t v;
    v.mode  = m;
    v.a0[0] = W'(x0);
    v.a0[1] = W'(x1);
    v.a0[2] = W'(x2);
    v.a0[3] = W'(x3);
    v.a1[0] = W'(y0);
    v.a1[1] = W'(y1);
    v.a1[2] = W'(y2);
    v.a1[3] = W'(y3);
    v.e0    = W'(e0);
    v.e1    = W'(e1);
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    in_if.valid = 1'b1;
    mode        = m;
    in_if.data  = {y, x};
    tick();
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    out_if.ready = 1'b1;
    tick();
    out_if.ready = 1'b0;
    check("drain_valid", longint'(out_if.valid), 0);
    check("drain_state", longint'(state), 0);
  endtask

  task automatic run_window(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      put(v.mode, v.a0[k], v.a1[k]);
      if (k < 3) check("early_valid", longint'(out_if.valid), 0);
    end
    check("valid", longint'(out_if.valid), 1);
    check("ch0", sx(out_if.data[W-1:0]), sx(v.e0));
    check("ch1", sx(out_if.data[2*W-1:W]), sx(v.e1));
    check("out_mode", longint'(out_mode), longint'(v.mode));
    check("out_state", longint'(state), 2);
    check("out_in_ready", longint'(in_if.ready), 0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    clear        = 1'b0;
    mode         = 2'b00;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    vecs[0] = mk(2'b00, 3, -5, 7, 1, -2, -9, -1, -4, 7, -1);
    vecs[1] = mk(2'b01, 4, 8, 12, -4, -1, 0, 0, 0, 5, -1);
    vecs[2] = mk(2'b10, 3, -5, 7, 1, -2, -9, -1, -4, -5, -9);
    vecs[3] = mk(2'b11, 524287, 524287, 524287, 524287,
                 -524288, -524288, -524288, -524288, 524287, -524288);
    vecs[4] = mk(2'b01, -3, -3, -3, -2, 7, 0, 0, 0, -3, 1);
    vecs[5] = mk(2'b11, 1, 2, 3, 4, -10, 5, -1, 0, 10, -6);

    tick();
    tick();
    reset = 1'b0;
    check("rst_state", longint'(state), 0);
    check("rst_valid", longint'(out_if.valid), 0);
    check("rst_data", longint'(out_if.data), 0);
    check("rst_mode", longint'(out_mode), 0);
    check("rst_in_ready", longint'(in_if.ready), 1);

    for (int i = 0; i < 6; i++) begin
      run_window(vecs[i]);
      drain();
    end

    // Gapped input followed by a held result under backpressure.
    for (int k = 0; k < 4; k++) begin
      put(vecs[0].mode, vecs[0].a0[k], vecs[0].a1[k]);
      if (k < 3) begin
        tick();
        check("gap_state", longint'(state), 1);
      end
    end
    check("bp_valid", longint'(out_if.valid), 1);
    in_if.valid = 1'b1;
    in_if.data  = {W'(100), W'(100)};
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_ch0", sx(out_if.data[W-1:0]), 7);
      check("bp_ch1", sx(out_if.data[2*W-1:W]), -1);
      check("bp_in_ready", longint'(in_if.ready), 0);
      check("bp_state", longint'(state), 2);
    end
    in_if.valid = 1'b0;
    drain();

    // Clear mid-window with a same-cycle element that must be dropped.
    put(2'b00, W'(100), W'(100));
    put(2'b00, W'(100), W'(100));
    clear       = 1'b1;
    in_if.valid = 1'b1;
    in_if.data  = {W'(200), W'(200)};
    tick();
    clear       = 1'b0;
    in_if.valid = 1'b0;
    check("clr_state", longint'(state), 0);
    check("clr_valid", longint'(out_if.valid), 0);
    put(2'b00, W'(1), W'(4));
    put(2'b10, W'(2), W'(3));
    put(2'b10, W'(3), W'(2));
    check("clr_early_valid", longint'(out_if.valid), 0);
    put(2'b10, W'(4), W'(1));
    check("clr_valid_res", longint'(out_if.valid), 1);
    check("clr_ch0", sx(out_if.data[W-1:0]), 4);
    check("clr_ch1", sx(out_if.data[2*W-1:W]), 4);
    check("clr_mode", longint'(out_mode), 0);
    drain();

    // Reset while accumulating, then while presenting a result.
    put(2'b01, W'(5), W'(5));
    put(2'b01, W'(5), W'(5));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("racc_state", longint'(state), 0);
    check("racc_valid", longint'(out_if.valid), 0);
    check("racc_data", longint'(out_if.data), 0);
    run_window(vecs[1]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rout_state", longint'(state), 0);
    check("rout_valid", longint'(out_if.valid), 0);
    check("rout_data", longint'(out_if.data), 0);
    check("rout_mode", longint'(out_mode), 0);
    run_window(vecs[2]);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
